rv32a_amo_seq: RTL and testbench
================================

RV32A_AMO_SEQ -- requirements
Module: rv32a_amo_seq

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, meaning word-address width of the data RAM.
REQ-002 SHALL have port iCLK  in  1  system clock, single domain; all state on rising edge.
REQ-003 SHALL have port iRST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iREQ_VALID  in  1  atomic request valid.
REQ-005 SHALL have port oREQ_READY  out  1  request accepted when both high on a rising edge.
REQ-006 SHALL have port iFUNC3  in  3  funct3 of the A-extension instruction.
REQ-007 SHALL have port iFUNC5  in  5  funct5 (instruction bits 31:27).
REQ-008 SHALL have port iADDR  in  32  byte address (rs1 value).
REQ-009 SHALL have port iDATA  in  32  operand (rs2 value).
REQ-010 SHALL have port iRES_CLR  in  1  pulse: invalidate reservation (trap/context switch).
REQ-011 SHALL have ports oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM strobes.
REQ-012 SHALL have ports oRAM_ADDR  out  RAM_AW  word address (iADDR>>2), iRAM_DATA  in  32  read data, oRAM_DATA  out  32  write data.
REQ-013 SHALL have ports oRSP_VALID  out  1, iRSP_READY  in  1, oRSP_DATA  out  32 (value for rd), oRSP_ERR  out  1.

Function
REQ-014 SHALL use states IDLE, RD, CALC, WR, RSP; oREQ_READY = (state==IDLE).
REQ-015 SHALL latch func5, address, operand on acceptance; inputs ignored outside IDLE.
REQ-016 SHALL flag error (oRSP_ERR=1, oRSP_DATA=0, IDLE->RSP, no RAM strobe) when iFUNC3!=3'b010, iADDR[1:0]!=0, or func5 not in {00,01,02,03,04,08,0C,10,14,18,1C}.
REQ-017 SHALL in RD assert CE+RD for exactly one cycle; RAM data valid on iRAM_DATA in CALC.
REQ-018 SHALL in CALC capture old = iRAM_DATA into oRSP_DATA and compute new: 00 add (mod 2^32), 01 swap, 04 xor, 0C and, 08 or, 10 signed min, 14 signed max, 18 unsigned min, 1C unsigned max.
REQ-019 SHALL in WR assert CE+WR for exactly one cycle with oRAM_DATA=new; AMO latency accept->oRSP_VALID = 4 cycles.
REQ-020 SHALL for LR (02) go IDLE->RD->CALC->RSP, return old value, set reservation valid with word address.
REQ-021 SHALL for SC (03) skip RD: if reservation valid and word address matches -> WR with iDATA, result 0; else IDLE->RSP, result 1, no write.
REQ-022 SHALL clear reservation on every SC (success or fail), on WR to the reserved word by any AMO, and on iRES_CLR.
REQ-023 SHALL give iRES_CLR priority over a same-cycle LR reservation set (reservation ends invalid).
REQ-024 SHALL hold oRSP_VALID, oRSP_DATA, oRSP_ERR stable in RSP until iRSP_READY; then IDLE next cycle.
REQ-025 SHALL keep oRAM_CE/RD/WR low in IDLE, CALC, RSP; oRAM_DATA=0 except in WR.

Reset
REQ-026 SHALL on iRST_N low immediately force state IDLE, reservation invalid, all outputs 0 except oREQ_READY=1.
REQ-027 SHALL abandon any in-flight operation on reset mid-operation; no partial write completes after reset release.

Configuration
REQ-028 SHALL honour macro RV32A_RESERVATION_EN: defined -> REQ-020..023 as written.
REQ-029 SHALL without RV32A_RESERVATION_EN omit reservation registers; LR behaves as plain load, SC always fails (result 1, no write), iRES_CLR ignored.

Structure
REQ-030 SHALL place func5 encodings, funct3 code 3'b010, and the state enum in shared package rv32a_pkg.
REQ-031 SHALL implement REQ-018 op compute in combinational sub-module rv32a_amo_alu (inputs func5, old, operand; output new).

Verification
REQ-032 SHALL check: RAM[4]=5, AMOADD addr 0x10 data 3 -> rsp 5, RAM[4]=8, valid 4 cycles after accept.
REQ-033 SHALL check: RAM[2]=0xFFFFFFFF, AMOMAX data 1 -> RAM[2]=1; AMOMAXU data 1 -> RAM[2]=0xFFFFFFFF.
REQ-034 SHALL check: LR 0x20, SC 0x20 data 7 -> rsp 0, RAM[8]=7; second SC -> rsp 1, no WR strobe.
REQ-035 SHALL check: LR 0x20, iRES_CLR pulse, SC 0x20 -> rsp 1; repeat with LR, AMOSWAP 0x20, SC -> rsp 1.
REQ-036 SHALL check: AMOADD addr 0x12 -> oRSP_ERR=1, no RAM strobes; iRSP_READY low 3 cycles -> outputs stable.
REQ-037 SHALL check: iRST_N low during WR of AMOOR -> strobes drop immediately, RAM unchanged, oREQ_READY=1.

Source files
------------

// File: rtl/rv32a_pkg.sv
// Shared encodings for the RV32A atomic sequencer: funct3/funct5 codes,
// sequencer state enum and the funct5 legality helper.
package rv32a_pkg;

  localparam logic [2:0] FUNCT3_AMO = 3'b010;

  localparam logic [4:0] F5_ADD  = 5'h00;
  localparam logic [4:0] F5_SWAP = 5'h01;
  localparam logic [4:0] F5_LR   = 5'h02;
  localparam logic [4:0] F5_SC   = 5'h03;
  localparam logic [4:0] F5_XOR  = 5'h04;
  localparam logic [4:0] F5_OR   = 5'h08;
  localparam logic [4:0] F5_AND  = 5'h0C;
  localparam logic [4:0] F5_MIN  = 5'h10;
  localparam logic [4:0] F5_MAX  = 5'h14;
  localparam logic [4:0] F5_MINU = 5'h18;
  localparam logic [4:0] F5_MAXU = 5'h1C;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CALC = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_e;

  function automatic logic func5_legal(input logic [4:0] f5);
    case (f5)
      F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
      F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32a_amo_seq_if.sv
// Request, RAM and response bus of the RV32A atomic sequencer.
// slave = sequencer view, master = requester/RAM side.
interface rv32a_amo_seq_if #(
  parameter int RAM_AW = 8
) ();
  logic              iREQ_VALID;
  logic              oREQ_READY;
  logic [2:0]        iFUNC3;
  logic [4:0]        iFUNC5;
  logic [31:0]       iADDR;
  logic [31:0]       iDATA;
  logic              iRES_CLR;
  logic              oRAM_CE;
  logic              oRAM_RD;
  logic              oRAM_WR;
  logic [RAM_AW-1:0] oRAM_ADDR;
  logic [31:0]       iRAM_DATA;
  logic [31:0]       oRAM_DATA;
  logic              oRSP_VALID;
  logic              iRSP_READY;
  logic [31:0]       oRSP_DATA;
  logic              oRSP_ERR;

  modport slave (
    input  iREQ_VALID, iFUNC3, iFUNC5, iADDR, iDATA, iRES_CLR, iRAM_DATA, iRSP_READY,
    output oREQ_READY, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA,
           oRSP_VALID, oRSP_DATA, oRSP_ERR
  );

  modport master (
    output iREQ_VALID, iFUNC3, iFUNC5, iADDR, iDATA, iRES_CLR, iRAM_DATA, iRSP_READY,
    input  oREQ_READY, oRAM_CE, oRAM_RD, oRAM_WR, oRAM_ADDR, oRAM_DATA,
           oRSP_VALID, oRSP_DATA, oRSP_ERR
  );
endinterface

// File: rtl/rv32a_amo_alu.sv
// Combinational AMO operator: new memory value from old value and rs2 operand.
module rv32a_amo_alu
  import rv32a_pkg::*;
(
  input  logic [4:0]  func5_i,
  input  logic [31:0] old_i,
  input  logic [31:0] operand_i,
  output logic [31:0] new_o
);

  // Select the read-modify-write result; non-AMO codes leave memory as read.
  always_comb begin
    new_o = old_i;
    case (func5_i)
      F5_ADD:  new_o = old_i + operand_i;
      F5_SWAP: new_o = operand_i;
      F5_XOR:  new_o = old_i ^ operand_i;
      F5_OR:   new_o = old_i | operand_i;
      F5_AND:  new_o = old_i & operand_i;
      F5_MIN:  new_o = ($signed(old_i) < $signed(operand_i)) ? old_i : operand_i;
      F5_MAX:  new_o = ($signed(old_i) > $signed(operand_i)) ? old_i : operand_i;
      F5_MINU: new_o = (old_i < operand_i) ? old_i : operand_i;
      F5_MAXU: new_o = (old_i > operand_i) ? old_i : operand_i;
      default: new_o = old_i;
    endcase
  end

endmodule

// File: rtl/rv32a_amo_seq.sv
// RV32A atomic sequencer: AMO read-modify-write and LR/SC over a synchronous RAM.
// Optional macro RV32A_RESERVATION_EN builds the LR/SC reservation register.
module rv32a_amo_seq
  import rv32a_pkg::*;
#(
  parameter int RAM_AW = 8
) (
  input logic            iCLK,
  input logic            iRST_N,
  rv32a_amo_seq_if.slave bus
);

  state_e            state_q;
  logic [4:0]        func5_q;
  logic [RAM_AW-1:0] waddr_q;
  logic [31:0]       opnd_q;
  logic              ram_ce_q;
  logic              ram_rd_q;
  logic              ram_wr_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [31:0]       ram_wdata_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;

  logic [31:0]       amo_new_d;
  logic [RAM_AW-1:0] req_waddr_s;
  logic              req_legal_s;
  logic              sc_ok_s;
  logic              unused_addr_s;

  assign req_waddr_s   = bus.iADDR[RAM_AW+1:2];
  assign req_legal_s   = (bus.iFUNC3 == FUNCT3_AMO) && (bus.iADDR[1:0] == 2'b00) &&
                         func5_legal(bus.iFUNC5);
  assign unused_addr_s = ^bus.iADDR[31:RAM_AW+2];

  rv32a_amo_alu u_alu (
    .func5_i   (func5_q),
    .old_i     (bus.iRAM_DATA),
    .operand_i (opnd_q),
    .new_o     (amo_new_d)
  );

`ifdef RV32A_RESERVATION_EN
  logic              res_valid_q;
  logic [RAM_AW-1:0] res_addr_q;

  assign sc_ok_s = res_valid_q && (res_addr_q == req_waddr_s);

  // Reservation: every clear source outranks the LR set in the same cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= {RAM_AW{1'b0}};
    end else if (bus.iRES_CLR) begin
      res_valid_q <= 1'b0;
    end else if ((state_q == IDLE) && bus.iREQ_VALID && req_legal_s && (bus.iFUNC5 == F5_SC)) begin
      res_valid_q <= 1'b0;
    end else if ((state_q == WR) && (res_addr_q == waddr_q)) begin
      res_valid_q <= 1'b0;
    end else if ((state_q == CALC) && (func5_q == F5_LR)) begin
      res_valid_q <= 1'b1;
      res_addr_q  <= waddr_q;
    end else begin
      res_valid_q <= res_valid_q;
    end
  end
`else
  logic unused_res_clr_s;

  assign sc_ok_s          = 1'b0;
  assign unused_res_clr_s = bus.iRES_CLR;
`endif

  // Sequencer FSM; all bus outputs are registered here.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= IDLE;
      func5_q     <= 5'h00;
      waddr_q     <= {RAM_AW{1'b0}};
      opnd_q      <= 32'h0000_0000;
      ram_ce_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= {RAM_AW{1'b0}};
      ram_wdata_q <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.iREQ_VALID) begin
            func5_q    <= bus.iFUNC5;
            waddr_q    <= req_waddr_s;
            opnd_q     <= bus.iDATA;
            rsp_data_q <= 32'h0000_0000;
            rsp_err_q  <= 1'b0;
            if (!req_legal_s) begin
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RSP;
            end else if (bus.iFUNC5 == F5_SC) begin
              if (sc_ok_s) begin
                ram_ce_q    <= 1'b1;
                ram_wr_q    <= 1'b1;
                ram_addr_q  <= req_waddr_s;
                ram_wdata_q <= bus.iDATA;
                state_q     <= WR;
              end else begin
                rsp_data_q  <= 32'h0000_0001;
                rsp_valid_q <= 1'b1;
                state_q     <= RSP;
              end
            end else begin
              ram_ce_q   <= 1'b1;
              ram_rd_q   <= 1'b1;
              ram_addr_q <= req_waddr_s;
              state_q    <= RD;
            end
          end
        end
        RD: begin
          ram_ce_q   <= 1'b0;
          ram_rd_q   <= 1'b0;
          ram_addr_q <= {RAM_AW{1'b0}};
          state_q    <= CALC;
        end
        CALC: begin
          rsp_data_q <= bus.iRAM_DATA;
          if (func5_q == F5_LR) begin
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            ram_ce_q    <= 1'b1;
            ram_wr_q    <= 1'b1;
            ram_addr_q  <= waddr_q;
            ram_wdata_q <= amo_new_d;
            state_q     <= WR;
          end
        end
        WR: begin
          ram_ce_q    <= 1'b0;
          ram_wr_q    <= 1'b0;
          ram_addr_q  <= {RAM_AW{1'b0}};
          ram_wdata_q <= 32'h0000_0000;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
        end
        RSP: begin
          if (bus.iRSP_READY) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          ram_ce_q    <= 1'b0;
          ram_rd_q    <= 1'b0;
          ram_wr_q    <= 1'b0;
          ram_wdata_q <= 32'h0000_0000;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.oREQ_READY = (state_q == IDLE);
  assign bus.oRAM_CE    = ram_ce_q;
  assign bus.oRAM_RD    = ram_rd_q;
  assign bus.oRAM_WR    = ram_wr_q;
  assign bus.oRAM_ADDR  = ram_addr_q;
  assign bus.oRAM_DATA  = ram_wdata_q;
  assign bus.oRSP_VALID = rsp_valid_q;
  assign bus.oRSP_DATA  = rsp_data_q;
  assign bus.oRSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_rv32a_amo_seq.sv
// Scoreboard bench for rv32a_amo_seq: directed cases plus random traffic vs. a reference model.
// Honours RV32A_RESERVATION_EN in its model.
module tb_rv32a_amo_seq;

`ifdef RV32A_RESERVATION_EN
  localparam bit RES_EN = 1'b1;
`else
  localparam bit RES_EN = 1'b0;
`endif

  localparam logic [4:0] ADD = 5'h00, SWAP = 5'h01, LR = 5'h02, SC = 5'h03, XOR_ = 5'h04;
  localparam logic [4:0] OR_ = 5'h08, AND_ = 5'h0C, MIN = 5'h10, MAX = 5'h14;
  localparam logic [4:0] MINU = 5'h18, MAXU = 5'h1C;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  rv32a_amo_seq_if #(.RAM_AW(8)) bus ();

  rv32a_amo_seq #(.RAM_AW(8)) dut (.iCLK(clk), .iRST_N(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_chk, n_pass;
  int          cyc, acc_cyc, rsp_done, lo_hold;
  int          wr_cnt, rd_cnt;
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        ref_res_v;
  int          ref_res_a;
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;
  exp_t        exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM with a preload port
  always @(posedge clk) begin
    if (pre_we) mem[pre_a] <= pre_d;
    else if (bus.oRAM_CE && bus.oRAM_WR) begin
      mem[bus.oRAM_ADDR] <= bus.oRAM_DATA;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.oRAM_CE && bus.oRAM_RD) begin
      bus.iRAM_DATA <= mem[bus.oRAM_ADDR];
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Response-ready driver: random backpressure, or forced low while lo_hold runs
  initial begin
    bus.iRSP_READY = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.oRSP_VALID && lo_hold > 0) begin
        bus.iRSP_READY = 1'b0;
        lo_hold--;
      end else bus.iRSP_READY = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on each new response, checks hold stability and bus invariants
  initial begin
    logic        in_rsp;
    logic [31:0] h_data;
    logic        h_err;
    exp_t        e;
    in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_rsp = 1'b0;
      else begin
        chk("bus_invariant",
            {31'd0, !(bus.oREQ_READY && bus.oRAM_CE) && (bus.oRAM_CE == (bus.oRAM_RD | bus.oRAM_WR)) &&
                    !(bus.oRAM_RD && bus.oRAM_WR) && (bus.oRAM_WR || bus.oRAM_DATA == 32'd0)}, 32'd1);
        if (bus.oRSP_VALID) begin
          if (!in_rsp) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_q.pop_front();
              chk("rsp_data", bus.oRSP_DATA, e.data);
              chk("rsp_err", {31'd0, bus.oRSP_ERR}, {31'd0, e.err});
              chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
            h_data = bus.oRSP_DATA;
            h_err  = bus.oRSP_ERR;
            in_rsp = 1'b1;
          end else begin
            chk("hold_data", bus.oRSP_DATA, h_data);
            chk("hold_err", {31'd0, bus.oRSP_ERR}, {31'd0, h_err});
          end
          if (bus.iRSP_READY) begin
            in_rsp = 1'b0;
            rsp_done++;
          end
        end
      end
    end
  end

  // Reference model: one atomic op at a time on ref_mem/reservation
  task automatic model(input logic [2:0] f3, input logic [4:0] f5, input logic [31:0] a,
                       input logic [31:0] d, output exp_t e, output int n_rd, output int n_wr);
    int          w;
    logic [31:0] old;
    logic [31:0] nv;
    w      = int'(a[9:2]);
    old    = ref_mem[w];
    e.data = old;
    e.err  = 1'b0;
    e.lat  = 4;
    n_rd   = 1;
    n_wr   = 1;
    if (f3 != 3'b010 || a[1:0] != 2'b00 ||
        !(f5 inside {ADD, SWAP, LR, SC, XOR_, OR_, AND_, MIN, MAX, MINU, MAXU})) begin
      e.data = 32'd0; e.err = 1'b1; e.lat = 1; n_rd = 0; n_wr = 0;
    end else if (f5 == LR) begin
      e.lat = 3; n_wr = 0;
      ref_res_v = RES_EN;
      ref_res_a = w;
    end else if (f5 == SC) begin
      n_rd = 0;
      if (RES_EN && ref_res_v && ref_res_a == w) begin
        ref_mem[w] = d; e.data = 32'd0; e.lat = 2;
      end else begin
        e.data = 32'd1; e.lat = 1; n_wr = 0;
      end
      ref_res_v = 1'b0;
    end else begin
      case (f5)
        ADD:     nv = old + d;
        SWAP:    nv = d;
        XOR_:    nv = old ^ d;
        OR_:     nv = old | d;
        AND_:    nv = old & d;
        MIN:     nv = ($signed(old) < $signed(d)) ? old : d;
        MAX:     nv = ($signed(old) > $signed(d)) ? old : d;
        MINU:    nv = (old < d) ? old : d;
        default: nv = (old > d) ? old : d;
      endcase
      ref_mem[w] = nv;
      if (ref_res_v && ref_res_a == w) ref_res_v = 1'b0;
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_a = 8'(w); pre_d = v;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[w] = v;
  endtask

  task automatic res_clr_pulse();
    @(negedge clk);
    bus.iRES_CLR = 1'b1;
    @(negedge clk);
    bus.iRES_CLR = 1'b0;
    ref_res_v = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] f5, input logic [31:0] a,
                       input logic [31:0] d);
    exp_t e;
    int   x_rd, x_wr, rd0, wr0, done0, n;
    model(f3, f5, a, d, e, x_rd, x_wr);
    exp_q.push_back(e);
    rd0 = rd_cnt; wr0 = wr_cnt; done0 = rsp_done;
    @(negedge clk);
    bus.iREQ_VALID = 1'b1; bus.iFUNC3 = f3; bus.iFUNC5 = f5; bus.iADDR = a; bus.iDATA = d;
    n = 0;
    while (!bus.oREQ_READY && n < 50) begin @(negedge clk); n++; end
    acc_cyc = cyc;
    @(negedge clk);
    bus.iREQ_VALID = 1'b0;
    bus.iFUNC3 = 3'($urandom); bus.iFUNC5 = 5'($urandom); bus.iADDR = $urandom; bus.iDATA = $urandom;
    n = 0;
    while (rsp_done == done0 && n < 200) begin @(negedge clk); n++; end
    chk("rsp_timeout", {31'd0, rsp_done != done0}, 32'd1);
    if (rsp_done == done0) exp_q.delete();
    @(negedge clk);
    chk("rd_strobes", 32'(rd_cnt - rd0), 32'(x_rd));
    chk("wr_strobes", 32'(wr_cnt - wr0), 32'(x_wr));
    chk("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [11];
    logic [4:0] f5;
    logic [2:0] f3;
    logic [31:0] a, d;
    int r, seen;
    ops = '{ADD, SWAP, LR, SC, XOR_, OR_, AND_, MIN, MAX, MINU, MAXU};
    n_chk = 0; n_pass = 0; lo_hold = 0; ref_res_v = 1'b0; ref_res_a = 0;
    rst_n = 1'b0; pre_we = 1'b0; pre_a = 8'd0; pre_d = 32'd0;
    bus.iREQ_VALID = 1'b0; bus.iFUNC3 = 3'd0; bus.iFUNC5 = 5'd0; bus.iADDR = 32'd0;
    bus.iDATA = 32'd0; bus.iRES_CLR = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.oREQ_READY}, 32'd1);
    chk("rst_strobes", {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'd0);
    chk("rst_rsp", {30'd0, bus.oRSP_VALID, bus.oRSP_ERR}, 32'd0);
    chk("rst_rsp_data", bus.oRSP_DATA, 32'd0);
    chk("rst_ram_data", bus.oRAM_DATA, 32'd0);
    for (int w = 0; w < 256; w++) poke(w, $urandom);
    @(negedge clk);
    rst_n = 1'b1;

    poke(4, 32'd5);
    issue(3'b010, ADD, 32'h10, 32'd3);
    chk("amoadd_mem", mem[4], 32'd8);

    poke(2, 32'hFFFF_FFFF);
    issue(3'b010, MAX, 32'h08, 32'd1);
    chk("amomax_mem", mem[2], 32'd1);
    issue(3'b010, MAXU, 32'h08, 32'hFFFF_FFFF);
    issue(3'b010, MINU, 32'h08, 32'd1);
    chk("amominu_mem", mem[2], 32'd1);
    poke(2, 32'hFFFF_FFFF);
    issue(3'b010, MAXU, 32'h08, 32'd1);
    chk("amomaxu_mem", mem[2], 32'hFFFF_FFFF);

    issue(3'b010, LR, 32'h20, 32'd0);
    issue(3'b010, SC, 32'h20, 32'd7);
    issue(3'b010, SC, 32'h20, 32'd9);

    issue(3'b010, LR, 32'h20, 32'd0);
    res_clr_pulse();
    issue(3'b010, SC, 32'h20, 32'd11);
    issue(3'b010, LR, 32'h20, 32'd0);
    issue(3'b010, SWAP, 32'h20, 32'h55);
    issue(3'b010, SC, 32'h20, 32'd12);
    issue(3'b010, LR, 32'h24, 32'd0);
    issue(3'b010, SWAP, 32'h20, 32'h66);
    issue(3'b010, SC, 32'h24, 32'd13);

    lo_hold = 3;
    issue(3'b010, ADD, 32'h12, 32'd1);
    issue(3'b011, ADD, 32'h10, 32'd1);
    issue(3'b010, 5'h05, 32'h10, 32'd1);

    // Reset during the write phase of an AMOOR
    poke(12, 32'h1234_0000);
    wr_cnt = wr_cnt;
    @(negedge clk);
    bus.iREQ_VALID = 1'b1; bus.iFUNC3 = 3'b010; bus.iFUNC5 = OR_; bus.iADDR = 32'h30;
    bus.iDATA = 32'h0000_F0F0;
    @(negedge clk);
    bus.iREQ_VALID = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (bus.oRAM_WR) seen = 1;
      else @(negedge clk);
    end
    chk("rst_wr_seen", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {29'd0, bus.oRAM_CE, bus.oRAM_RD, bus.oRAM_WR}, 32'd0);
    chk("rst_mid_ready", {31'd0, bus.oREQ_READY}, 32'd1);
    chk("rst_mid_rsp", {31'd0, bus.oRSP_VALID}, 32'd0);
    ref_res_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_mem", mem[12], 32'h1234_0000);
    rst_n = 1'b1;

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 8) f5 = 5'($urandom);
      else if (r < 19) f5 = LR;
      else if (r < 30) f5 = SC;
      else f5 = ops[$urandom_range(0, 10)];
      f3 = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b010;
      a = 32'($urandom_range(0, 7)) * 32'd4;
      if ($urandom_range(0, 19) == 0) a = a + 32'($urandom_range(1, 3));
      case ($urandom_range(0, 2))
        0:       d = 32'($urandom_range(0, 15));
        1:       d = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) res_clr_pulse();
      issue(f3, f5, a, d);
    end

    for (int w = 0; w < 256; w++) chk("final_mem", mem[w], ref_mem[w]);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
